// File: rtl/sq_wqe_fetch.sv
// Send-queue WQE fetch: turns SQ doorbells into one-at-a-time 64-byte WQE host reads and forwards each beat with its QP.
// Optional SQ_FETCH_STATS_EN adds a saturating forwarded-WQE counter on stat_wqe_cnt.
//
// state | meaning
// IDLE  | accept doorbell or consumer-index clear
// LOAD  | read cons[qp] from the table
// CHECK | compare producer against consumer, pick fetch/done/overflow
// REQ   | present DMA read for the current ring slot
// DATA  | wait for the WQE beat
// OUT   | forward the WQE, advance the consumer index
module sq_wqe_fetch #(
    parameter int         NUM_QP       = 256,
    parameter int         SQ_DEPTH     = 64,
    parameter int         WQE_BYTES    = 64,
    parameter logic [3:0] ACCESDESC_RD = 4'h1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_sq_valid,
    output logic         s_sq_ready,
    input  logic [167:0] s_sq_data,
    input  logic         s_clr_valid,
    input  logic [7:0]   s_clr_qp,
    output logic         m_dma_valid,
    input  logic         m_dma_ready,
    output logic [115:0] m_dma_data,
    input  logic         s_wqe_valid,
    output logic         s_wqe_ready,
    input  logic [511:0] s_wqe_data,
    output logic         m_wqe_valid,
    input  logic         m_wqe_ready,
    output logic [511:0] m_wqe_data,
    output logic [7:0]   m_wqe_qp,
    output logic         err_overflow,
    output logic [31:0]  stat_wqe_cnt
);
    localparam int SLOT_BITS = $clog2(SQ_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_REQ, S_DATA, S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   cons_tbl [NUM_QP];
    logic [7:0]    qp_r;
    logic [63:0]   base_r;
    logic [31:0]   prod_r;
    logic [31:0]   cons_r;
    logic [511:0]  wqe_hold;
    logic [31:0]   diff;
    logic [31:0]   cons_inc;
    logic [63:0]   slot_off;
    logic          pd_vaddr_unused;

    assign pd_vaddr_unused = ^s_sq_data[63:0];
    assign diff     = prod_r - cons_r;
    assign cons_inc = cons_r + 32'd1;
    assign slot_off = 64'(cons_r[SLOT_BITS-1:0]) * 64'(WQE_BYTES);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        s_sq_ready  = 1'b0;
        m_dma_valid = 1'b0;
        s_wqe_ready = 1'b0;
        m_wqe_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // a same-cycle clear wins; the doorbell waits one cycle
                s_sq_ready = !s_clr_valid;
                if (s_sq_valid && !s_clr_valid) state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (diff == 32'd0 || diff > 32'(SQ_DEPTH)) state_nxt = S_IDLE;
                else                                       state_nxt = S_REQ;
            end
            S_REQ: begin
                m_dma_valid = 1'b1;
                if (m_dma_ready) state_nxt = S_DATA;
            end
            S_DATA: begin
                s_wqe_ready = 1'b1;
                if (s_wqe_valid) state_nxt = S_OUT;
            end
            S_OUT: begin
                m_wqe_valid = 1'b1;
                if (m_wqe_ready) state_nxt = S_CHECK;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_QP; i++) cons_tbl[i] <= '0;
        end else if (state == S_IDLE && s_clr_valid) begin
            cons_tbl[s_clr_qp] <= '0;
        end else if (state == S_OUT && m_wqe_ready) begin
            cons_tbl[qp_r] <= cons_inc;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            qp_r         <= '0;
            base_r       <= '0;
            prod_r       <= '0;
            cons_r       <= '0;
            wqe_hold     <= '0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (s_sq_valid && s_sq_ready) begin
                    qp_r   <= s_sq_data[167:160];
                    base_r <= s_sq_data[159:96];
                    prod_r <= s_sq_data[95:64];
                end
                S_LOAD:  cons_r <= cons_tbl[qp_r];
                S_CHECK: if (diff > 32'(SQ_DEPTH)) err_overflow <= 1'b1;
                S_DATA:  if (s_wqe_valid) wqe_hold <= s_wqe_data;
                // next CHECK works from the incremented index, no table re-read
                S_OUT:   if (m_wqe_ready) cons_r <= cons_inc;
                default: ;
            endcase
        end
    end

    assign m_dma_data = (state == S_REQ) ?
                        {ACCESDESC_RD, 48'(WQE_BYTES), base_r + slot_off} : '0;
    assign m_wqe_data = wqe_hold;
    assign m_wqe_qp   = qp_r;

`ifdef SQ_FETCH_STATS_EN
    logic [31:0] stat_r;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            stat_r <= '0;
        else if (m_wqe_valid && m_wqe_ready && stat_r != 32'hFFFF_FFFF)
            stat_r <= stat_r + 32'd1;
    end
    assign stat_wqe_cnt = stat_r;
`else
    assign stat_wqe_cnt = '0;
`endif

endmodule

// File: tb/tb_sq_wqe_fetch.sv
// Scoreboard bench for sq_wqe_fetch: a queue-based ring model predicts DMA reads and forwarded WQEs.
`timescale 1ns/1ps
module tb_sq_wqe_fetch;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_sq_valid = 1'b0;
    logic         s_sq_ready;
    logic [167:0] s_sq_data = '0;
    logic         s_clr_valid = 1'b0;
    logic [7:0]   s_clr_qp = '0;
    logic         m_dma_valid;
    logic         m_dma_ready = 1'b1;
    logic [115:0] m_dma_data;
    logic         s_wqe_valid = 1'b0;
    logic         s_wqe_ready;
    logic [511:0] s_wqe_data = '0;
    logic         m_wqe_valid;
    logic         m_wqe_ready = 1'b1;
    logic [511:0] m_wqe_data;
    logic [7:0]   m_wqe_qp;
    logic         err_overflow;
    logic [31:0]  stat_wqe_cnt;

    always #5 aclk = ~aclk;

    sq_wqe_fetch dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
        .s_clr_valid(s_clr_valid), .s_clr_qp(s_clr_qp),
        .m_dma_valid(m_dma_valid), .m_dma_ready(m_dma_ready), .m_dma_data(m_dma_data),
        .s_wqe_valid(s_wqe_valid), .s_wqe_ready(s_wqe_ready), .s_wqe_data(s_wqe_data),
        .m_wqe_valid(m_wqe_valid), .m_wqe_ready(m_wqe_ready), .m_wqe_data(m_wqe_data),
        .m_wqe_qp(m_wqe_qp), .err_overflow(err_overflow), .stat_wqe_cnt(stat_wqe_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned  cons_m [256];
    logic         ovf_m = 1'b0;
    int unsigned  stat_m = 0;
    logic [115:0] exp_dma_q [$];
    logic [7:0]   exp_dma_qp [$];
    logic [519:0] exp_wqe_q [$];
    logic [7:0]   rsp_pend [$];
    bit           bp_en = 1'b0;
    bit           rsp_hold = 1'b0;
    int           dma_cnt = 0;
    bit           wqe_acc = 1'b0;

    task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    function automatic logic [31:0] exp_stat();
`ifdef SQ_FETCH_STATS_EN
        return stat_m;
`else
        return 32'd0;
`endif
    endfunction

    // ring model: every outstanding index between cons and prod is one 64-byte read
    function automatic void model_doorbell(input logic [7:0] qp, input logic [63:0] base,
                                           input int unsigned prod);
        int unsigned d;
        d = prod - cons_m[qp];
        if (d == 0) return;
        if (d > 64) begin
            ovf_m = 1'b1;
            return;
        end
        for (int unsigned i = 0; i < d; i++) begin
            int unsigned c;
            c = cons_m[qp] + i;
            exp_dma_q.push_back({4'h1, 48'd64, base + 64'((c % 64) * 64)});
            exp_dma_qp.push_back(qp);
        end
        cons_m[qp] = prod;
    endfunction

    // monitor / scoreboard
    initial begin
        logic pdv, pda, pwv, pwa;
        logic [115:0] pdd;
        logic [519:0] pwd;
        pdv = 0; pda = 0; pwv = 0; pwa = 0; pdd = '0; pwd = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                pdv = 0; pwv = 0; wqe_acc = 0;
            end else begin
                if (pdv && !pda) chk("dma_hold", {m_dma_valid, m_dma_data}, {1'b1, pdd});
                if (pwv && !pwa) chk("wqe_hold", {m_wqe_valid, m_wqe_qp, m_wqe_data}, {1'b1, pwd});
                if (m_dma_valid && m_dma_ready) begin
                    if (exp_dma_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dma_unexpected: got %0h expected none", m_dma_data);
                    end else begin
                        chk("dma_req", m_dma_data, exp_dma_q.pop_front());
                        rsp_pend.push_back(exp_dma_qp.pop_front());
                        dma_cnt++;
                    end
                end
                if (m_wqe_valid && m_wqe_ready) begin
                    if (exp_wqe_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL wqe_unexpected: got qp %0h expected none", m_wqe_qp);
                    end else begin
                        chk("wqe_fwd", {m_wqe_qp, m_wqe_data}, exp_wqe_q.pop_front());
                        stat_m++;
                    end
                end
                pdv = m_dma_valid; pda = m_dma_ready; pdd = m_dma_data;
                pwv = m_wqe_valid; pwa = m_wqe_ready; pwd = {m_wqe_qp, m_wqe_data};
                wqe_acc = s_wqe_valid && s_wqe_ready;
            end
        end
    end

    // downstream/host readiness
    initial begin
        forever begin
            @(posedge aclk); #1;
            m_dma_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wqe_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // host memory: answers each accepted read with a random payload
    initial begin
        logic [511:0] d;
        logic [7:0] q;
        forever begin
            @(posedge aclk); #1;
            if (!aresetn) begin
                s_wqe_valid = 1'b0;
            end else begin
                if (s_wqe_valid && wqe_acc) s_wqe_valid = 1'b0;
                if (!s_wqe_valid && rsp_pend.size() > 0 && !rsp_hold &&
                    (!bp_en || $urandom_range(0, 2) == 0)) begin
                    q = rsp_pend.pop_front();
                    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
                    s_wqe_data  = d;
                    s_wqe_valid = 1'b1;
                    exp_wqe_q.push_back({q, d});
                end
            end
        end
    end

    task automatic doorbell(input logic [7:0] qp, input logic [63:0] base, input int unsigned prod);
        bit acc;
        acc = 0;
        @(posedge aclk); #1;
        s_sq_valid = 1'b1;
        s_sq_data  = {qp, base, prod, $urandom, $urandom};
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge aclk);
            if (s_sq_ready) acc = 1;
        end
        @(posedge aclk); #1;
        s_sq_valid = 1'b0;
        if (acc) model_doorbell(qp, base, prod);
        else     fail_now("doorbell_accept");
    endtask

    task automatic wait_idle();
        int stable;
        stable = 0;
        for (int i = 0; i < 4000 && stable < 3; i++) begin
            @(negedge aclk);
            if (exp_dma_q.size() == 0 && exp_wqe_q.size() == 0 && rsp_pend.size() == 0 &&
                !s_wqe_valid && s_sq_ready) stable++;
            else stable = 0;
        end
        if (stable < 3) fail_now("idle_wait");
    endtask

    initial begin
        int start;
        bit seen;
        logic [7:0] rq;
        int unsigned rp;
        for (int i = 0; i < 256; i++) cons_m[i] = 0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_ctrl", {s_sq_ready, s_wqe_ready, m_dma_valid, m_wqe_valid, err_overflow}, 5'b10000);
        chk("rst_dma_data", m_dma_data, '0);
        chk("rst_wqe_out", {m_wqe_qp, m_wqe_data}, '0);
        chk("rst_stat", stat_wqe_cnt, '0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // basic two-WQE fetch
        start = dma_cnt;
        doorbell(8'd3, 64'h1000_0000, 2);
        wait_idle();
        chk("t1_dma_count", dma_cnt - start, 2);
        chk("t1_sq_ready", s_sq_ready, 1'b1);
        chk("t1_stat", stat_wqe_cnt, exp_stat());

        // ring wrap on qp 5: cons 63 -> 65 uses slots 63 and 0
        start = dma_cnt;
        doorbell(8'd5, 64'h0000_0002_0000_0000, 63);
        wait_idle();
        doorbell(8'd5, 64'h0000_0002_0000_0000, 65);
        wait_idle();
        doorbell(8'd5, 64'h0000_0002_0000_0000, 65);
        wait_idle();
        doorbell(8'd5, 64'h0000_0002_0000_0000, 66);
        wait_idle();
        chk("t2_dma_count", dma_cnt - start, 66);
        chk("t2_ovf_clear", err_overflow, 1'b0);

        // overflow: prod 65 past cons 0, and prod behind cons
        start = dma_cnt;
        doorbell(8'd9, 64'h3000_0000, 65);
        wait_idle();
        chk("t3_ovf_set", err_overflow, ovf_m);
        doorbell(8'd10, 64'h3000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("t3_no_fetch", dma_cnt - start, 0);
        chk("t3_ovf_sticky", err_overflow, 1'b1);

        // back-pressure, then random doorbells
        bp_en = 1'b1;
        start = dma_cnt;
        doorbell(8'd11, 64'hABCD_0000_0000_1000, 4);
        wait_idle();
        chk("t4_dma_count", dma_cnt - start, 4);
        for (int n = 0; n < 12; n++) begin
            rq = 8'(20 + $urandom_range(0, 3));
            rp = cons_m[rq] + $urandom_range(0, 5);
            doorbell(rq, {$urandom, $urandom}, rp);
            wait_idle();
        end
        bp_en = 1'b0;
        chk("t4_ovf_sticky", err_overflow, 1'b1);
        chk("t4_stat", stat_wqe_cnt, exp_stat());

        // clear beats a same-cycle doorbell
        doorbell(8'd7, 64'h7000_0000, 10);
        wait_idle();
        start = dma_cnt;
        @(posedge aclk); #1;
        s_clr_valid = 1'b1;
        s_clr_qp    = 8'd7;
        s_sq_valid  = 1'b1;
        s_sq_data   = {8'd7, 64'h7000_0000, 32'd1, 64'd0};
        @(negedge aclk);
        chk("t5_clr_blocks_db", s_sq_ready, 1'b0);
        @(posedge aclk); #1;
        s_clr_valid = 1'b0;
        cons_m[7] = 0;
        @(negedge aclk);
        chk("t5_db_next_cycle", s_sq_ready, 1'b1);
        @(posedge aclk); #1;
        s_sq_valid = 1'b0;
        model_doorbell(8'd7, 64'h7000_0000, 1);
        wait_idle();
        chk("t5_dma_count", dma_cnt - start, 1);

        // reset while waiting in DATA
        rsp_hold = 1'b1;
        start = dma_cnt;
        doorbell(8'd3, 64'h1000_0000, cons_m[3] + 1);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge aclk);
            if (dma_cnt > start) seen = 1;
        end
        if (!seen) fail_now("t6_dma_seen");
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t6_in_data", s_wqe_ready, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_ctrl", {s_wqe_ready, m_dma_valid, m_wqe_valid, err_overflow}, 4'b0000);
        chk("t6_rst_data", {m_dma_data, m_wqe_qp, m_wqe_data}, '0);
        chk("t6_rst_stat", stat_wqe_cnt, '0);
        exp_dma_q.delete();
        exp_dma_qp.delete();
        exp_wqe_q.delete();
        rsp_pend.delete();
        for (int i = 0; i < 256; i++) cons_m[i] = 0;
        ovf_m = 1'b0;
        stat_m = 0;
        rsp_hold = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        start = dma_cnt;
        doorbell(8'd3, 64'h1000_0000, 1);
        wait_idle();
        chk("t6_refetch_count", dma_cnt - start, 1);
        chk("t6_ovf", err_overflow, ovf_m);
        chk("t6_stat", stat_wqe_cnt, exp_stat());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule
